pwm_multi: RTL

Multi-channel PWM generator with one shared time base: CHANNELS outputs, each with its own duty and polarity. Supports edge-aligned and center-aligned (up/down) counting. Period, duty and mode are double-buffered: a `load` strobe captures them and they take effect only at a period boundary, so output waveforms never glitch. Sits between the register/control logic and the pin mux; it is the parametrised successor to the single-channel PWM.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_multi_channel_cmp.sv | 46 ++++
 rtl/pwm_multi.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the multi-channel PWM generator.
//   pwm_mode_e    : counting mode of the shared time base.
//   pwm_dir_e     : count direction used by center-aligned mode.
//   PWM_WIDTH_DEFAULT / PWM_CH_MAX : default counter width, channel ceiling.
package pwm_pkg;

    localparam int PWM_WIDTH_DEFAULT = 16;
    localparam int PWM_CH_MAX        = 16;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_multi_channel_cmp.sv
// pwm_channel_cmp: one PWM output bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : time base running; when low the output sits at its inactive level
//   cnt_i      : shared counter value
//   duty_i     : active duty for this channel
//   pol_i      : 0 = active-high, 1 = active-low (live, not buffered)
//   pwm_o      : registered output
module pwm_channel_cmp
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic             pol_i,
    output logic             pwm_o
);

    logic pwm_d;
    logic pwm_q;

    // Next output level: compare result with polarity, or inactive level when stopped.
    always_comb begin
        pwm_d = 1'b0;
        if (en_i) begin
            pwm_d = (cnt_i < duty_i) ^ pol_i;
        end else begin
            pwm_d = pol_i;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with a shared, double-buffered time base.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : run enable; low = counter parked at 0, outputs inactive
//   load         : strobe capturing period/duty/center_mode into the shadow
//   period       : counts per cycle (edge) or per half-cycle (center)
//   duty         : channel i at bits [i*WIDTH +: WIDTH]
//   center_mode  : 0 = edge-aligned, 1 = center-aligned
//   polarity     : per-channel output inversion, applied live
//   pwm_out      : registered PWM outputs
//   period_tick  : one-cycle pulse in the first cycle of each new period
//   load_pending : shadow holds values not yet applied
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = PWM_WIDTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      center_mode,
    input  logic [CHANNELS-1:0]       polarity,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_tick,
    output logic                      load_pending
);

    typedef logic [CHANNELS-1:0][WIDTH-1:0] duty_vec_t;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    pwm_dir_e         dir_q, dir_d;
    logic             tick_q, tick_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] p_act_q, p_act_d, p_sh_q, p_sh_d;
    pwm_mode_e        mode_act_q, mode_act_d, mode_sh_q, mode_sh_d;
    duty_vec_t        d_act_q, d_act_d, d_sh_q, d_sh_d;

    duty_vec_t        duty_s;
    pwm_mode_e        mode_in_s;
    logic [WIDTH-1:0] p_last_s;
    logic             at_last_s;
    logic             boundary_s;
    logic             apply_s;

    assign duty_s    = duty;
    assign mode_in_s = pwm_mode_e'(center_mode);

    // A zero period behaves as a period of one, so the last count is 0 either way.
    assign p_last_s  = (p_act_q == {WIDTH{1'b0}}) ? {WIDTH{1'b0}} : (p_act_q - WIDTH'(1));
    assign at_last_s = (cnt_q == p_last_s);

    // Boundary: edge wrap, center down-to-up turn at 0, or every clock when the period is 0.
    always_comb begin
        boundary_s = 1'b0;
        if (!en) begin
            boundary_s = 1'b0;
        end else if (p_act_q == {WIDTH{1'b0}}) begin
            boundary_s = 1'b1;
        end else if (mode_act_q == PWM_EDGE) begin
            boundary_s = at_last_s;
        end else begin
            boundary_s = (dir_q == DIR_DOWN) && (cnt_q == {WIDTH{1'b0}});
        end
    end

    // While stopped, buffered values are applied straight away.
    assign apply_s = !en || boundary_s;

    // Next-state logic for time base and shadow/active register banks.
    always_comb begin
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        tick_d     = 1'b0;
        pending_d  = pending_q;
        p_act_d    = p_act_q;
        mode_act_d = mode_act_q;
        d_act_d    = d_act_q;
        p_sh_d     = p_sh_q;
        mode_sh_d  = mode_sh_q;
        d_sh_d     = d_sh_q;

        if (!en) begin
            cnt_d = {WIDTH{1'b0}};
            dir_d = DIR_UP;
        end else if (boundary_s) begin
            // Restarting at 0/up here also covers a mode change being applied.
            cnt_d  = {WIDTH{1'b0}};
            dir_d  = DIR_UP;
            tick_d = 1'b1;
        end else if (mode_act_q == PWM_EDGE) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else if (dir_q == DIR_UP) begin
            // Holding the count on the flip makes P-1 appear twice.
            if (at_last_s) begin
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else begin
            cnt_d = cnt_q - WIDTH'(1);
        end

        if (load) begin
            p_sh_d    = period;
            mode_sh_d = mode_in_s;
            d_sh_d    = duty_s;
        end else begin
            p_sh_d    = p_sh_q;
            mode_sh_d = mode_sh_q;
            d_sh_d    = d_sh_q;
        end

        if (apply_s) begin
            // A coincident load bypasses the shadow and never raises pending.
            if (load) begin
                p_act_d    = period;
                mode_act_d = mode_in_s;
                d_act_d    = duty_s;
            end else if (pending_q) begin
                p_act_d    = p_sh_q;
                mode_act_d = mode_sh_q;
                d_act_d    = d_sh_q;
            end else begin
                p_act_d    = p_act_q;
                mode_act_d = mode_act_q;
                d_act_d    = d_act_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= {WIDTH{1'b0}};
            dir_q      <= DIR_UP;
            tick_q     <= 1'b0;
            pending_q  <= 1'b0;
            p_act_q    <= {WIDTH{1'b0}};
            mode_act_q <= PWM_EDGE;
            d_act_q    <= '0;
            p_sh_q     <= {WIDTH{1'b0}};
            mode_sh_q  <= PWM_EDGE;
            d_sh_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            tick_q     <= tick_d;
            pending_q  <= pending_d;
            p_act_q    <= p_act_d;
            mode_act_q <= mode_act_d;
            d_act_q    <= d_act_d;
            p_sh_q     <= p_sh_d;
            mode_sh_q  <= mode_sh_d;
            d_sh_q     <= d_sh_d;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        pwm_channel_cmp #(
            .WIDTH (WIDTH)
        ) u_cmp (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (en),
            .cnt_i  (cnt_q),
            .duty_i (d_act_q[gi]),
            .pol_i  (polarity[gi]),
            .pwm_o  (pwm_out[gi])
        );
    end

    assign period_tick  = tick_q;
    assign load_pending = pending_q;

endmodule
